// File: rtl/b01_serial_driver_if.sv
// Operand/result bundle between the host side and b01_serial_driver.
// master = host (drives operands), slave = driver (returns results).
interface b01_serial_driver_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_ovf;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, res_valid, res_data, res_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, res_valid, res_data, res_ovf
    );
endinterface

// File: rtl/b01_serial_driver.sv
// Bit-serial operand transmitter and result collector for the b01 core.
// Ports: clock, reset_n, bus (operand/result handshake), line1/line2 out,
// outp/overflw in (serial return from the core).
module b01_serial_driver #(
    parameter int WIDTH = 8,
    parameter int LAT   = 1,
    parameter int GAP   = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    b01_serial_driver_if.slave  bus,
    output logic                line1,
    output logic                line2,
    input  logic                outp,
    input  logic                overflw
);

    localparam int CW = $clog2(WIDTH + 16);
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(LAT - 1);
    localparam logic [CW-1:0] LAST_GAP   = CW'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_DRAIN,
        S_DONE,
        S_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] cap_nxt;
    logic             acc;
    logic             acc_nxt;
    logic [CW-1:0]    cnt;
    logic             mark_in;
    logic             live;

    // A bit is "live" on the line for every SHIFT cycle; the mark is
    // delayed by LAT so it lines up with the core's returned sample.
    assign mark_in = (state == S_SHIFT);

    generate
        if (LAT == 0) begin : g_nodly
            assign live = mark_in;
        end else begin : g_dly
            logic [LAT-1:0] dl;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    dl <= '0;
                end else begin
                    dl <= (dl << 1) | LAT'(mark_in);
                end
            end
            assign live = dl[LAT-1];
        end
    endgenerate

    // Next capture value; also used to publish the word on the same
    // edge that takes the final sample.
    always_comb begin
        cap_nxt = cap;
        acc_nxt = acc;
        if (live) begin
            cap_nxt = {outp, cap[WIDTH-1:1]};
            acc_nxt = acc | overflw;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            bus.in_ready  <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_ovf   <= 1'b0;
            line1         <= 1'b0;
            line2         <= 1'b0;
            sa            <= '0;
            sb            <= '0;
            cap           <= '0;
            acc           <= 1'b0;
            cnt           <= '0;
        end else begin
            bus.res_valid <= 1'b0;
            cap           <= cap_nxt;
            acc           <= acc_nxt;
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        state        <= S_SHIFT;
                        bus.in_ready <= 1'b0;
                        line1        <= bus.in_a[0];
                        line2        <= bus.in_b[0];
                        sa           <= bus.in_a >> 1;
                        sb           <= bus.in_b >> 1;
                        cnt          <= '0;
                        cap          <= '0;
                        acc          <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (cnt == LAST_BIT) begin
                        line1 <= 1'b0;
                        line2 <= 1'b0;
                        cnt   <= '0;
                        if (LAT == 0) begin
                            state         <= S_DONE;
                            bus.res_valid <= 1'b1;
                            bus.res_data  <= cap_nxt;
                            bus.res_ovf   <= acc_nxt;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else begin
                        line1 <= sa[0];
                        line2 <= sb[0];
                        sa    <= sa >> 1;
                        sb    <= sb >> 1;
                        cnt   <= cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt == LAST_DRAIN) begin
                        state         <= S_DONE;
                        cnt           <= '0;
                        bus.res_valid <= 1'b1;
                        bus.res_data  <= cap_nxt;
                        bus.res_ovf   <= acc_nxt;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    cnt <= '0;
                    if (GAP == 0) begin
                        state        <= S_IDLE;
                        bus.in_ready <= 1'b1;
                    end else begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt == LAST_GAP) begin
                        state        <= S_IDLE;
                        bus.in_ready <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    bus.in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b01_serial_driver.sv
// Directed testbench for b01_serial_driver with a scoreboard of results.
// Covers LAT=1 (registered stub core) and LAT=0 (combinational stub).
module tb_b01_serial_driver;

    logic clock;
    logic reset_n;
    logic line1, line2, outp, overflw;
    logic l1z, l2z, outpz, ovfz;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    int res_cnt = 0;
    int res_cnt0 = 0;

    logic [8:0] sb[$];
    logic [8:0] sb0[$];

    b01_serial_driver_if #(.WIDTH(8)) bus ();
    b01_serial_driver_if #(.WIDTH(8)) bus0 ();

    b01_serial_driver #(.WIDTH(8), .LAT(1), .GAP(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .line1   (line1),
        .line2   (line2),
        .outp    (outp),
        .overflw (overflw)
    );

    b01_serial_driver #(.WIDTH(8), .LAT(0), .GAP(1)) dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0.slave),
        .line1   (l1z),
        .line2   (l2z),
        .outp    (outpz),
        .overflw (ovfz)
    );

    // Stub cores: registered for LAT=1, combinational for LAT=0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outp    <= 1'b0;
            overflw <= 1'b0;
        end else begin
            outp    <= line1 ^ line2;
            overflw <= line1 & line2;
        end
    end

    assign outpz = l1z ^ l2z;
    assign ovfz  = l1z & l2z;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (bus.res_valid) begin
            logic [8:0] e;
            res_cnt++;
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("res_data", 32'(bus.res_data), 32'(e[8:1]));
                chk("res_ovf", 32'(bus.res_ovf), 32'(e[0]));
            end
        end
    end

    always @(negedge clock) begin
        if (bus0.res_valid) begin
            logic [8:0] e;
            res_cnt0++;
            chk("sb0_nonempty", 32'(sb0.size() != 0), 32'd1);
            if (sb0.size() != 0) begin
                e = sb0.pop_front();
                chk("res0_data", 32'(bus0.res_data), 32'(e[8:1]));
                chk("res0_ovf", 32'(bus0.res_ovf), 32'(e[0]));
            end
        end
    end

    // Offer a word (called at a negedge); returns at the negedge of cycle 1.
    task automatic accept_word(input logic [7:0] a, input logic [7:0] b,
                               input bit hold, output int base);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && !bus.in_ready; i++) @(negedge clock);
        chk("accept_ready", 32'(bus.in_ready), 32'd1);
        sb.push_back({a ^ b, |(a & b)});
        @(posedge clock);
        @(negedge clock);
        base = cyc;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic run_word(input logic [7:0] a, input logic [7:0] b,
                            input string tag);
        int base;
        logic [15:0] l1, l2, rv, rdy;
        accept_word(a, b, 1'b0, base);
        l1 = '0; l2 = '0; rv = '0; rdy = '0;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) @(negedge clock);
            l1[c]  = line1;
            l2[c]  = line2;
            rv[c]  = bus.res_valid;
            rdy[c] = bus.in_ready;
        end
        chk({tag, "_line1"}, 32'(l1), 32'(16'(a) << 1));
        chk({tag, "_line2"}, 32'(l2), 32'(16'(b) << 1));
        chk({tag, "_valid"}, 32'(rv), 32'h0400);
        chk({tag, "_ready"}, 32'(rdy), 32'h7000);
    endtask

    initial begin
        int n1, n2, n;
        logic [15:0] rv, rdy, l1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus0.in_valid = 1'b0;
        bus0.in_a     = '0;
        bus0.in_b     = '0;
        reset_n       = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_lines", 32'({line1, line2}), 32'd0);
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_data", 32'(bus.res_data), 32'd0);
        chk("rst_ovf", 32'(bus.res_ovf), 32'd0);
        chk("rst0_ready", 32'(bus0.in_ready), 32'd1);
        reset_n = 1'b1;
        @(negedge clock);

        run_word(8'hA5, 8'h0F, "w_a5_0f");
        run_word(8'h00, 8'h00, "w_zero");

        n = res_cnt;
        accept_word(8'hFF, 8'h01, 1'b1, n1);
        accept_word(8'h3C, 8'hC3, 1'b1, n2);
        bus.in_valid = 1'b0;
        chk("held_spacing", 32'(n2 - n1), 32'd12);
        repeat (14) @(negedge clock);
        chk("held_results", 32'(res_cnt - n), 32'd2);

        accept_word(8'hFF, 8'hFF, 1'b0, n1);
        repeat (3) @(negedge clock);
        chk("pre_rst_line1", 32'(line1), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_lines", 32'({line1, line2}), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_data", 32'(bus.res_data), 32'd0);
        sb.delete();
        n = res_cnt;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (14) @(negedge clock);
        chk("rst_no_result", 32'(res_cnt - n), 32'd0);
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
        run_word(8'h12, 8'h34, "w_after_rst");

        n = res_cnt;
        accept_word(8'h81, 8'h18, 1'b0, n1);
        rv = '0; rdy = '0;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) @(negedge clock);
            rv[c]  = bus.res_valid;
            rdy[c] = bus.in_ready;
            if (c == 3) begin
                bus.in_a     = 8'h55;
                bus.in_b     = 8'hAA;
                bus.in_valid = 1'b1;
            end
            if (c == 10) bus.in_valid = 1'b0;
        end
        chk("busy_valid", 32'(rv), 32'h0400);
        chk("busy_ready", 32'(rdy), 32'h7000);
        chk("busy_results", 32'(res_cnt - n), 32'd1);

        bus0.in_a     = 8'hA5;
        bus0.in_b     = 8'h0F;
        bus0.in_valid = 1'b1;
        for (int i = 0; i < 40 && !bus0.in_ready; i++) @(negedge clock);
        chk("lat0_accept", 32'(bus0.in_ready), 32'd1);
        sb0.push_back({8'hA5 ^ 8'h0F, |(8'hA5 & 8'h0F)});
        @(posedge clock);
        @(negedge clock);
        bus0.in_valid = 1'b0;
        rv = '0; rdy = '0; l1 = '0;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) @(negedge clock);
            l1[c]  = l1z;
            rv[c]  = bus0.res_valid;
            rdy[c] = bus0.in_ready;
        end
        chk("lat0_line1", 32'(l1), 32'(16'h00A5 << 1));
        chk("lat0_valid", 32'(rv), 32'h0200);
        chk("lat0_ready", 32'(rdy), 32'h7800);
        chk("lat0_results", 32'(res_cnt0), 32'd1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("sb0_drained", 32'(sb0.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
